// File: rtl/bram_bytewrite_clr.sv
// bram_bytewrite_clr
//   Simple-dual-port block RAM with per-byte write enables, a 1- or 2-cycle
//   read pipeline and a built-in clear engine that writes CLEAR_VALUE to
//   every word, either after reset or when requested.
//
// Ports
//   clock           in   single clock, all logic on posedge
//   reset           in   synchronous, active-high
//   readEnable      in   read request this cycle
//   readAddress     in   read address
//   readData        out  read result, zero whenever readValid is low
//   readValid       out  readData holds a valid read result
//   writeEnable     in   write request this cycle
//   writeByteEnable in   one enable per BYTE_WIDTH lane of writeData
//   writeAddress    in   write address
//   writeData       in   write data
//   clearRequest    in   single-cycle pulse, starts a sweep when idle
//   clearBusy       out  sweep in progress, user requests are ignored
module bram_bytewrite_clr #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}},
  localparam int NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH,
  localparam int MEM_DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  readEnable,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  readValid,
  input  logic                  writeEnable,
  input  logic [NUM_BYTES-1:0]  writeByteEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  clearRequest,
  output logic                  clearBusy
);

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : gBadByteWidth
    $error("bram_bytewrite_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : gBadLatency
    $error("bram_bytewrite_clr: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic [0:0] {
    stIdle  = 1'b0,
    stClear = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic                  ARM_ON_RESET = (CLEAR_ON_RESET != 0);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] clearCnt_r;
  logic                  armed_r;      // auto-sweep pending after reset
  logic                  clearBusy_r;
  logic                  s1Valid_r;
  logic [DATA_WIDTH-1:0] s1Data_r;

  logic [DATA_WIDTH-1:0] oldWord_s;
  logic [DATA_WIDTH-1:0] mergedWord_s;
  logic [DATA_WIDTH-1:0] readWord_s;
  logic                  collide_s;
  logic                  userIdle_s;

  // Read-side word selection, including same-address collision forwarding.
  always_comb begin
    userIdle_s   = (state_r == stIdle);
    oldWord_s    = mem[readAddress];
    mergedWord_s = oldWord_s;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (writeByteEnable[i]) begin
        mergedWord_s[i*BYTE_WIDTH +: BYTE_WIDTH] = writeData[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        mergedWord_s[i*BYTE_WIDTH +: BYTE_WIDTH] = oldWord_s[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    collide_s = readEnable && writeEnable && userIdle_s && (readAddress == writeAddress);
    if (collide_s && (WRITE_MODE == 0)) begin
      readWord_s = mergedWord_s;
    end else begin
      readWord_s = oldWord_s;
    end
  end

  // Array writes: the sweep owns the array while clearing, user lanes otherwise.
  always_ff @(posedge clock) begin
    if (!reset && (state_r == stClear)) begin
      mem[clearCnt_r] <= CLEAR_VALUE;
    end else if (!reset && writeEnable && (state_r == stIdle)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (writeByteEnable[i]) begin
          mem[writeAddress][i*BYTE_WIDTH +: BYTE_WIDTH] <= writeData[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Clear FSM: reset parks in idle with the auto-sweep armed, so clearBusy stays low during reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= stIdle;
      clearCnt_r  <= CNT_ZERO;
      armed_r     <= ARM_ON_RESET;
      clearBusy_r <= 1'b0;
    end else begin
      case (state_r)
        stIdle: begin
          if (armed_r || clearRequest) begin
            state_r     <= stClear;
            clearCnt_r  <= CNT_ZERO;
            armed_r     <= 1'b0;
            clearBusy_r <= 1'b1;
          end
        end
        stClear: begin
          clearCnt_r <= clearCnt_r + CNT_ONE;
          if (clearCnt_r == CNT_LAST) begin
            state_r     <= stIdle;
            clearBusy_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= stIdle;
          clearCnt_r  <= CNT_ZERO;
          armed_r     <= 1'b0;
          clearBusy_r <= 1'b0;
        end
      endcase
    end
  end

  // First read stage: array output register; data forced to zero when no read.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1Valid_r <= 1'b0;
      s1Data_r  <= {DATA_WIDTH{1'b0}};
    end else if (readEnable && (state_r == stIdle)) begin
      s1Valid_r <= 1'b1;
      s1Data_r  <= readWord_s;
    end else begin
      s1Valid_r <= 1'b0;
      s1Data_r  <= {DATA_WIDTH{1'b0}};
    end
  end

  if (READ_LATENCY == 2) begin : gLat2
    logic                  s2Valid_r;
    logic [DATA_WIDTH-1:0] s2Data_r;

    // Second read stage: plain pipeline copy of the first stage.
    always_ff @(posedge clock) begin
      if (reset) begin
        s2Valid_r <= 1'b0;
        s2Data_r  <= {DATA_WIDTH{1'b0}};
      end else begin
        s2Valid_r <= s1Valid_r;
        s2Data_r  <= s1Data_r;
      end
    end

    assign readValid = s2Valid_r;
    assign readData  = s2Data_r;
  end else begin : gLat1
    assign readValid = s1Valid_r;
    assign readData  = s1Data_r;
  end

  assign clearBusy = clearBusy_r;

endmodule

// File: tb/tb_bram_bytewrite_clr.sv
module tb_bram_bytewrite_clr;

  localparam logic [31:0] CV = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset;
  logic        readEnable;
  logic [3:0]  readAddress;
  logic        writeEnable;
  logic [3:0]  writeByteEnable;
  logic [3:0]  writeAddress;
  logic [31:0] writeData;
  logic        clearRequest;

  logic [31:0] rd0, rd1;
  logic        rv0, rv1, busy0, busy1;

  int checks = 0;
  int errors = 0;
  int n0, n1, guard;

  always #5 clock = ~clock;

  // Write-first, latency 1
  bram_bytewrite_clr #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .READ_LATENCY(1),
    .WRITE_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut0 (
    .clock(clock), .reset(reset),
    .readEnable(readEnable), .readAddress(readAddress),
    .readData(rd0), .readValid(rv0),
    .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
    .writeAddress(writeAddress), .writeData(writeData),
    .clearRequest(clearRequest), .clearBusy(busy0)
  );

  // Read-first, latency 2
  bram_bytewrite_clr #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .READ_LATENCY(2),
    .WRITE_MODE(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut1 (
    .clock(clock), .reset(reset),
    .readEnable(readEnable), .readAddress(readAddress),
    .readData(rd1), .readValid(rv1),
    .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
    .writeAddress(writeAddress), .writeData(writeData),
    .clearRequest(clearRequest), .clearBusy(busy1)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; readEnable = 1'b0; readAddress = 4'd0; writeEnable = 1'b0;
    writeByteEnable = 4'h0; writeAddress = 4'd0; writeData = 32'h0; clearRequest = 1'b0;
    repeat (3) step();
    check("rst_rv0", {31'd0, rv0}, 32'd0);
    check("rst_rd0", rd0, 32'd0);
    check("rst_rv1", {31'd0, rv1}, 32'd0);
    check("rst_rd1", rd1, 32'd0);
    check("rst_busy0", {31'd0, busy0}, 32'd0);

    // T1: sweep after reset lasts exactly 16 cycles
    reset = 1'b0;
    n0 = 0; n1 = 0; guard = 0;
    step();
    while ((busy0 || busy1) && guard < 40) begin
      n0 += int'(busy0); n1 += int'(busy1); guard++;
      step();
    end
    check("t1_busy_len0", n0, 32'd16);
    check("t1_busy_len1", n1, 32'd16);
    for (int i = 0; i < 17; i++) begin
      readEnable  = (i < 16);
      readAddress = 4'(i);
      step();
      if (i < 16) begin
        check("t1_rd0", rd0, CV);
        check("t1_rv0", {31'd0, rv0}, 32'd1);
      end
      if (i >= 1) check("t1_rd1", rd1, CV);
    end
    check("t1_idle_rv0", {31'd0, rv0}, 32'd0);
    check("t1_idle_rd0", rd0, 32'd0);
    readEnable = 1'b0;
    step();
    check("t1_idle_rv1", {31'd0, rv1}, 32'd0);

    // T2: byte lanes, plus an all-lanes-disabled write
    writeEnable = 1'b1; writeAddress = 4'd5; writeByteEnable = 4'b1111; writeData = 32'h1122_3344;
    step();
    writeByteEnable = 4'b0101; writeData = 32'hAABB_CCDD;
    step();
    writeByteEnable = 4'b0000; writeData = 32'h0000_0000;
    step();
    writeEnable = 1'b0; readEnable = 1'b1; readAddress = 4'd5;
    step();
    check("t2_lanes0", rd0, 32'h11BB_33DD);
    readEnable = 1'b0;
    step();
    check("t2_lanes1", rd1, 32'h11BB_33DD);
    check("t2_noread_rd0", rd0, 32'd0);

    // T3: collision at address 7
    writeEnable = 1'b1; writeAddress = 4'd7; writeByteEnable = 4'b1111; writeData = 32'h0;
    step();
    writeByteEnable = 4'b0011; writeData = 32'hFFFF_FFFF; readEnable = 1'b1; readAddress = 4'd7;
    step();
    check("t3_coll_wf", rd0, 32'h0000_FFFF);
    writeEnable = 1'b0; readEnable = 1'b1;
    step();
    check("t3_coll_rf", rd1, 32'h0000_0000);
    check("t3_after0", rd0, 32'h0000_FFFF);
    readEnable = 1'b0;
    step();
    check("t3_after1", rd1, 32'h0000_FFFF);

    // T4: pipelined reads, latency-2 ordering
    writeEnable = 1'b1; writeByteEnable = 4'b1111;
    for (int i = 1; i <= 3; i++) begin
      writeAddress = 4'(i); writeData = 32'h0101_0101 * i;
      step();
    end
    writeEnable = 1'b0;
    readEnable = 1'b1; readAddress = 4'd1;
    step();
    check("t4_early_rv1", {31'd0, rv1}, 32'd0);
    readAddress = 4'd2;
    step();
    check("t4_v1", {31'd0, rv1}, 32'd1);
    check("t4_d1", rd1, 32'h0101_0101);
    readAddress = 4'd3;
    step();
    check("t4_d2", rd1, 32'h0202_0202);
    readEnable = 1'b0;
    step();
    check("t4_d3", rd1, 32'h0303_0303);
    step();
    check("t4_late_rv1", {31'd0, rv1}, 32'd0);

    // T5: requests during a sweep are ignored
    clearRequest = 1'b1;
    step();
    clearRequest = 1'b0;
    n0 = 0;
    while (busy0 && n0 < 40) begin
      n0++;
      if (n0 == 2) begin
        writeEnable = 1'b1; writeByteEnable = 4'b1111; writeAddress = 4'd3;
        writeData = 32'h1234_5678; readEnable = 1'b1; readAddress = 4'd3;
      end else if (n0 == 3) begin
        check("t5_rv0_ignored", {31'd0, rv0}, 32'd0);
        writeAddress = 4'd0; readEnable = 1'b0;
      end else if (n0 == 4) begin
        check("t5_rv1_ignored", {31'd0, rv1}, 32'd0);
        writeEnable = 1'b0;
      end else if (n0 == 6) begin
        clearRequest = 1'b1;
      end else if (n0 == 7) begin
        clearRequest = 1'b0;
      end
      step();
    end
    check("t5_sweep_len", n0, 32'd16);
    readEnable = 1'b1; readAddress = 4'd3;
    step();
    check("t5_ram3_0", rd0, CV);
    readAddress = 4'd0;
    step();
    check("t5_ram0_0", rd0, CV);
    check("t5_ram3_1", rd1, CV);
    readEnable = 1'b0;
    step();
    check("t5_ram0_1", rd1, CV);

    // T6: reset mid-sweep restarts a full sweep
    clearRequest = 1'b1;
    step();
    clearRequest = 1'b0;
    repeat (4) step();
    check("t6_busy_mid", {31'd0, busy0}, 32'd1);
    reset = 1'b1;
    step();
    check("t6_rv0", {31'd0, rv0}, 32'd0);
    check("t6_rd0", rd0, 32'd0);
    check("t6_rv1", {31'd0, rv1}, 32'd0);
    check("t6_busy0", {31'd0, busy0}, 32'd0);
    reset = 1'b0;
    n0 = 0; guard = 0;
    step();
    while (busy0 && guard < 40) begin
      n0++; guard++;
      step();
    end
    check("t6_sweep_len", n0, 32'd16);
    readEnable = 1'b1; readAddress = 4'd12;
    step();
    check("t6_ram12_0", rd0, CV);
    readEnable = 1'b0;
    step();
    check("t6_ram12_1", rd1, CV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
